// File: rtl/divsqrt_pkg.sv
// rtl/divsqrt_pkg.sv - shared FSM state encoding and flag bit positions for the divSqrt arbiter
package divsqrt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  localparam int FLAGS_W        = 5;
  localparam int RM_W           = 3;
  localparam int FLAG_INVALID   = 4;
  localparam int FLAG_INFINITE  = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin pick starting one past the last grant
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  // Walk last+1, last+2, ... wrapping at N; the first active request wins.
  always_comb begin : pick
    int                 cand;
    logic [IDX_W-1:0]   cand_w;
    cand    = 0;
    cand_w  = '0;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int off = 1; off <= N; off++) begin
      cand   = (int'(last_i) + off) % N;
      cand_w = IDX_W'(cand);
      if (!valid_o && req_i[cand_w]) begin
        valid_o       = 1'b1;
        gnt_o[cand_w] = 1'b1;
        idx_o         = cand_w;
      end
    end
  end

endmodule

// File: rtl/divsqrt_arbiter.sv
// rtl/divsqrt_arbiter.sv - shares one divSqrt unit between NUM_REQ requesters, one op in flight
module divsqrt_arbiter
  import divsqrt_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int EXP_WIDTH = 8,
  parameter  int SIG_WIDTH = 24,
  localparam int REC_W     = EXP_WIDTH + SIG_WIDTH + 1,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ-1:0]       req_sqrt_i,
  input  logic [NUM_REQ*REC_W-1:0] req_a_i,
  input  logic [NUM_REQ*REC_W-1:0] req_b_i,
  input  logic [NUM_REQ*RM_W-1:0]  req_rm_i,
  output logic                     unit_in_valid_o,
  output logic                     unit_sqrt_o,
  output logic [REC_W-1:0]         unit_a_o,
  output logic [REC_W-1:0]         unit_b_o,
  output logic [RM_W-1:0]          unit_rm_o,
  input  logic                     unit_in_ready_i,
  input  logic                     unit_out_valid_i,
  input  logic [REC_W-1:0]         unit_out_i,
  input  logic [FLAGS_W-1:0]       unit_flags_i,
  output logic                     rsp_valid_o,
  output logic [ID_W-1:0]          rsp_id_o,
  output logic [REC_W-1:0]         rsp_result_o,
  output logic [FLAGS_W-1:0]       rsp_flags_o,
  input  logic                     rsp_ready_i,
  output logic                     err_o
);

  localparam logic [ID_W-1:0] LAST_RST = ID_W'(NUM_REQ - 1);

  state_e               state_q;
  logic [ID_W-1:0]      last_q;
  logic                 in_valid_q;
  logic                 sqrt_q;
  logic [REC_W-1:0]     a_q;
  logic [REC_W-1:0]     b_q;
  logic [RM_W-1:0]      rm_q;
  logic                 rsp_valid_q;
  logic [ID_W-1:0]      rsp_id_q;
  logic [REC_W-1:0]     rsp_result_q;
  logic [FLAGS_W-1:0]   rsp_flags_q;
  logic                 err_q;

  logic [NUM_REQ-1:0]   arb_gnt;
  logic [ID_W-1:0]      arb_idx;
  logic                 arb_valid;

  logic                 sel_sqrt;
  logic [REC_W-1:0]     sel_a;
  logic [REC_W-1:0]     sel_b;
  logic [RM_W-1:0]      sel_rm;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_rr (
    .req_i   (req_valid_i),
    .last_i  (last_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  // Operand mux for the current winner; only sampled in IDLE.
  always_comb begin
    sel_sqrt = req_sqrt_i[arb_idx];
    sel_a    = req_a_i[arb_idx*REC_W +: REC_W];
    sel_b    = req_b_i[arb_idx*REC_W +: REC_W];
    sel_rm   = req_rm_i[arb_idx*RM_W +: RM_W];
  end

  // Grant is combinational in IDLE only; held off while reset is asserted so outputs read 0.
  assign req_ready_o = (state_q == ST_IDLE && rst_ni) ? arb_gnt : '0;

  // Single FSM: latch winner, issue, wait for result, hold response until consumed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      last_q       <= LAST_RST;
      in_valid_q   <= 1'b0;
      sqrt_q       <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      rm_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      // A result with nothing in flight is a protocol violation; ignore it but remember.
      if (unit_out_valid_i && state_q != ST_BUSY) begin
        err_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (arb_valid) begin
            last_q     <= arb_idx;
            sqrt_q     <= sel_sqrt;
            a_q        <= sel_a;
            b_q        <= sel_sqrt ? '0 : sel_b;
            rm_q       <= sel_rm;
            in_valid_q <= 1'b1;
            state_q    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (unit_in_ready_i) begin
            in_valid_q <= 1'b0;
            state_q    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (unit_out_valid_i) begin
            rsp_result_q <= unit_out_i;
            rsp_flags_q  <= unit_flags_i;
            rsp_id_q     <= last_q;
            rsp_valid_q  <= 1'b1;
            state_q      <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign unit_in_valid_o = in_valid_q;
  assign unit_sqrt_o     = sqrt_q;
  assign unit_a_o        = a_q;
  assign unit_b_o        = b_q;
  assign unit_rm_o       = rm_q;
  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_id_o        = rsp_id_q;
  assign rsp_result_o    = rsp_result_q;
  assign rsp_flags_o     = rsp_flags_q;
  assign err_o           = err_q;

endmodule

// File: doc/divsqrt_arbiter.md
DIVSQRT_ARBITER -- requirements
Module: divsqrt_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter EXP_WIDTH, default 8, recoded exponent width.
REQ-003 SHALL have parameter SIG_WIDTH, default 24, significand width; REC_W = EXP_WIDTH+SIG_WIDTH+1.
REQ-004 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid_i  input  NUM_REQ  per-requester request valid.
REQ-007 SHALL have port req_ready_o  output  NUM_REQ  per-requester grant/accept, one-hot or zero.
REQ-008 SHALL have port req_sqrt_i  input  NUM_REQ  1 = sqrt(a), 0 = a/b.
REQ-009 SHALL have port req_a_i  input  NUM_REQ*REC_W  flattened recoded operand a, requester k at slice k.
REQ-010 SHALL have port req_b_i  input  NUM_REQ*REC_W  flattened recoded operand b.
REQ-011 SHALL have port req_rm_i  input  NUM_REQ*3  flattened rounding mode.
REQ-012 SHALL have port unit_in_valid_o, unit_sqrt_o, unit_a_o, unit_b_o, unit_rm_o  output  1/1/REC_W/REC_W/3  issue to shared divSqrt unit.
REQ-013 SHALL have port unit_in_ready_i  input  1  unit ready to accept.
REQ-014 SHALL have port unit_out_valid_i, unit_out_i, unit_flags_i  input  1/REC_W/5  unit result pulse (no backpressure), result, {invalid,infinite,overflow,underflow,inexact}.
REQ-015 SHALL have port rsp_valid_o, rsp_id_o, rsp_result_o, rsp_flags_o  output  1/$clog2(NUM_REQ)/REC_W/5  response to requesters.
REQ-016 SHALL have port rsp_ready_i  input  1  response consumer ready.
REQ-017 SHALL have port err_o  output  1  sticky protocol error.

Function
REQ-018 SHALL implement FSM IDLE, ISSUE, BUSY, HOLD; exactly one operation in flight.
REQ-019 IDLE: if any req_valid_i, SHALL assert req_ready_o for the round-robin winner combinationally, latch its sqrt/a/b/rm and id, go ISSUE.
REQ-020 Round-robin SHALL search from last_grant+1 mod NUM_REQ upward; last_grant resets to NUM_REQ-1 so requester 0 wins first.
REQ-021 ISSUE: unit_in_valid_o=1 with latched operands held stable; on unit_in_ready_i=1 same cycle, go BUSY.
REQ-022 unit_b_o SHALL be driven 0 when the latched op is sqrt.
REQ-023 BUSY: on unit_out_valid_i, SHALL capture unit_out_i, unit_flags_i, latched id into response registers, go HOLD.
REQ-024 HOLD: rsp_valid_o=1, response fields stable; on rsp_ready_i, go IDLE; next grant no earlier than the following cycle.
REQ-025 req_ready_o SHALL be zero in ISSUE, BUSY, HOLD; unit_in_valid_o zero outside ISSUE; rsp_valid_o zero outside HOLD.
REQ-026 Grant-to-issue latency SHALL be 1 cycle; result-to-rsp_valid latency 1 cycle.
REQ-027 unit_out_valid_i outside BUSY SHALL be ignored (no state change) and set err_o until reset.
REQ-028 A requester dropping req_valid_i while not granted SHALL lose nothing; granted operands are already latched.

Reset
REQ-029 rst_ni low SHALL immediately force state IDLE, last_grant NUM_REQ-1, all outputs and data registers 0, err_o 0, including mid-operation.
REQ-030 The shared unit SHALL share rst_ni so an aborted operation produces no later result.

Structure
REQ-031 FSM state enum and flag bit positions SHALL live in shared package divsqrt_pkg.
REQ-032 Round-robin selection SHALL be sub-module rr_arbiter (request vector, last_grant -> one-hot grant, index).
REQ-033 Integration wrapper SHALL connect unit_* ports to divSqrtRecFN_small; this block does not instantiate it.

Verification (f32, operands IEEE-converted at bench edge)
REQ-034 Req 0 sqrt 0x41400000, RNE -> rsp_id 0, result 0x405db3d7, flags 5'h01.
REQ-035 Req 1 sqrt 0xc2140000 -> rsp_id 1, result NaN, flags 5'h10 (invalid).
REQ-036 All four valid from reset, rsp_ready_i=1 -> service order 0,1,2,3; req 0 re-asserting is served after 1,2,3.
REQ-037 rsp_ready_i low 50 cycles in HOLD -> rsp fields stable, req_ready_o and unit_in_valid_o stay 0.
REQ-038 Stub unit with unit_in_ready_i low 10 cycles -> unit_in_valid_o held 10 cycles, operands unchanged.
REQ-039 rst_ni low during BUSY, stray unit_out_valid_i in IDLE -> outputs 0 immediately; stray pulse sets err_o, no rsp_valid_o.
